banco_registradores: RTL

Register file for the datapath. It holds 32 general-purpose registers and drives the two operands, `entrada1` and `entrada2`, of the ULA directly downstream of it. Both read ports are registered with 1-cycle latency. The single write port takes the write-back result and commits it on the clock edge. Register 0 always reads as zero.

---
 rtl/banco_registradores.sv | 67 ++++++
 1 files changed

// File: rtl/banco_registradores.sv
// 32 x LARGURA register file: one write port, two registered read ports, r0 hardwired to zero.
// Define BANCO_BYPASS_EN for write-first reads on a same-cycle address match; read-first otherwise.
module banco_registradores #(
   parameter int LARGURA  = 32,
   parameter int NUM_REGS = 32
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [4:0]         regLeitura1,
   input  logic [4:0]         regLeitura2,
   input  logic [4:0]         regEscrita,
   input  logic [LARGURA-1:0] dadoEscrita,
   input  logic               escreveReg,
   output logic [LARGURA-1:0] dadoLeitura1,
   output logic [LARGURA-1:0] dadoLeitura2
);

   localparam int ADDR_W = 5;

   logic [LARGURA-1:0]  registradores [NUM_REGS];
   logic [NUM_REGS-1:0] habilitaEscrita;
   logic [LARGURA-1:0]  leitura1Next;
   logic [LARGURA-1:0]  leitura2Next;

   // One-hot write decode; r0 never gets an enable.
   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : gDecode
         if (gi == 0) begin : gZero
            assign habilitaEscrita[gi] = 1'b0;
         end else begin : gReg
            assign habilitaEscrita[gi] = escreveReg && (regEscrita == ADDR_W'(gi));
         end
      end
   endgenerate

   always_comb begin
      leitura1Next = registradores[regLeitura1];
      leitura2Next = registradores[regLeitura2];
`ifdef BANCO_BYPASS_EN
      if (escreveReg && (regEscrita == regLeitura1) && (regLeitura1 != '0))
         leitura1Next = dadoEscrita;
      if (escreveReg && (regEscrita == regLeitura2) && (regLeitura2 != '0))
         leitura2Next = dadoEscrita;
`endif
      if (regLeitura1 == '0)
         leitura1Next = '0;
      if (regLeitura2 == '0)
         leitura2Next = '0;
   end

   // Reset clears storage and outputs, and drops any write presented alongside it.
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++)
            registradores[i] <= '0;
         dadoLeitura1 <= '0;
         dadoLeitura2 <= '0;
      end else begin
         for (int i = 1; i < NUM_REGS; i++)
            if (habilitaEscrita[i])
               registradores[i] <= dadoEscrita;
         dadoLeitura1 <= leitura1Next;
         dadoLeitura2 <= leitura2Next;
      end
   end

endmodule
